bcd_stopwatch_ctrl: RTL and testbench

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

---
 rtl/bcd_stopwatch_ctrl.sv | 137 +++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: IDLE/RUN/PAUSE sequencer driving a prescaled
// cascade of decade digits, with a lap freeze register and a sticky
// overflow flag.
//
// Command interface: start/stop/clear/lap are level-sampled strobes, one
// action per rising edge. There is no handshake and no back-pressure.
// Priority is clear > stop > start, so a stop blocks a simultaneous start
// in every state.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] display,
  output logic                running,
  output logic                overflow,
  output logic [1:0]          state_dbg
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic                hold_q, hold_d;
  logic                ovf_q, ovf_d;
  logic                running_q, running_d;
  logic [4*DIGITS-1:0] cnt_inc;
  logic                all_nines;
  logic                tick;

  // A tick fires on the last prescaler phase while running.
  assign tick = (state_q == S_RUN) && (presc_q == PRE_LAST);

  // Ripple a +1 through the decade digits; the final carry means all were 9.
  always_comb begin : incrementer
    logic carry;
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // Next-state logic for the sequencer, prescaler, digits, lap and overflow.
  always_comb begin : next_state
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    if (clear) begin
      // Clear wins over everything, including a tick at this edge.
      state_d = S_IDLE;
      presc_d = '0;
      cnt_d   = '0;
      lap_d   = '0;
      hold_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      // The prescaler only advances when the pre-edge state is RUN.
      if (state_q == S_RUN) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        cnt_d = cnt_inc;
        if (all_nines) begin
          ovf_d = 1'b1;
        end
      end
      // Lap freezes the pre-edge count, so a coincident tick is not captured.
      if (lap && (state_q != S_IDLE)) begin
        hold_d = ~hold_q;
        if (!hold_q) begin
          lap_d = cnt_q;
        end
      end
      if (stop) begin
        if (state_q == S_RUN) begin
          state_d = S_PAUSE;
        end
      end else if (start && (state_q != S_RUN)) begin
        state_d = S_RUN;
      end
    end
    running_d = (state_d == S_RUN);
  end

  // State registers with asynchronous reset to the idle, zeroed condition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      lap_q     <= '0;
      hold_q    <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      hold_q    <= hold_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

  assign display   = hold_q ? lap_q : cnt_q;
  assign running   = running_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl (DIGITS=2, PRESCALE=2): directed scenarios
// plus random commands, checked cycle by cycle against an integer model.
module tb_bcd_stopwatch_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 2;
  localparam int W        = 4*DIGITS + 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                stop  = 1'b0;
  logic                clear = 1'b0;
  logic                lap   = 1'b0;
  logic [4*DIGITS-1:0] display;
  logic                running;
  logic                overflow;
  logic [1:0]          state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  // Integer model: state 0=idle 1=run 2=pause, count as a plain number.
  int m_state = 0;
  int m_cnt   = 0;
  int m_pre   = 0;
  int m_lap   = 0;
  bit m_hold  = 0;
  bit m_ovf   = 0;

  bcd_stopwatch_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap       (lap),
    .display   (display),
    .running   (running),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // Clock: period 100.
  always #50 clock = ~clock;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pre = 0; m_lap = 0; m_hold = 0; m_ovf = 0;
  endtask

  // One rising edge of the model, from the stopwatch rules.
  task automatic model_edge(input bit st, input bit sp, input bit cl, input bit lp);
    bit tick;
    if (cl) begin
      model_reset();
      return;
    end
    tick = (m_state == 1) && (m_pre == PRESCALE - 1);
    if (lp && m_state != 0) begin
      if (!m_hold) m_lap = m_cnt;
      m_hold = !m_hold;
    end
    if (m_state == 1) m_pre = tick ? 0 : m_pre + 1;
    if (tick) begin
      if (m_cnt == 99) m_ovf = 1;
      m_cnt = (m_cnt + 1) % 100;
    end
    if (sp) begin
      if (m_state == 1) m_state = 2;
    end else if (st && m_state != 1) begin
      m_state = 1;
    end
  endtask

  // Driver: apply commands for the coming edge and queue the expected outputs.
  task automatic step(input bit st, input bit sp, input bit cl, input bit lp);
    @(negedge clock);
    start = st; stop = sp; clear = cl; lap = lp;
    model_edge(st, sp, cl, lp);
    exp_q.push_back({to_bcd(m_hold ? m_lap : m_cnt), (m_state == 1), m_ovf});
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: after every rising edge compare the DUT against the queued model output.
  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({display, running, overflow} !== e) begin
        failures++;
        $display("FAIL scoreboard @%0t: got disp=%h run=%b ovf=%b expected disp=%h run=%b ovf=%b",
                 $time, display, running, overflow, e[W-1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    // Reset state.
    #60;
    chk("reset_display", display, 0);
    chk("reset_running", running, 0);
    chk("reset_overflow", overflow, 0);
    #40;
    reset = 1'b0;

    // First tick timing and decade carry.
    step(1, 0, 0, 0);
    chk("start_running", running, 1);
    chk("start_display", display, 8'h00);
    for (int e = 1; e <= 20; e++) begin
      step(0, 0, 0, 0);
      if (e == 1)  chk("k+1_display", display, 8'h00);
      if (e == 2)  chk("k+2_display", display, 8'h01);
      if (e == 18) chk("k+18_display", display, 8'h09);
      if (e == 20) chk("k+20_display", display, 8'h10);
    end

    // Run through 99 and wrap.
    for (int e = 1; e <= 180; e++) begin
      step(0, 0, 0, 0);
      if (e == 178) chk("at_99", display, 8'h99);
    end
    chk("wrap_display", display, 8'h00);
    chk("wrap_overflow", overflow, 1);
    chk("wrap_running", running, 1);
    idle(3);
    chk("overflow_sticky", overflow, 1);
    step(0, 0, 1, 0);
    chk("clear_overflow", overflow, 0);
    chk("clear_display", display, 8'h00);
    chk("clear_running", running, 0);

    // Pause with prescaler mid-phase, then resume.
    step(1, 0, 0, 0);
    idle(10);
    step(0, 1, 0, 0);
    chk("pause_display", display, 8'h05);
    chk("pause_running", running, 0);
    idle(10);
    chk("paused_hold_display", display, 8'h05);
    step(1, 0, 0, 0);
    chk("resume_display", display, 8'h05);
    chk("resume_running", running, 1);
    step(0, 0, 0, 0);
    chk("resume_phase", display, 8'h06);

    // Lap freeze and release.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    idle(6);
    chk("pre_lap", display, 8'h03);
    step(0, 0, 0, 1);
    chk("lap_frozen", display, 8'h03);
    idle(7);
    chk("lap_still_frozen", display, 8'h03);
    step(0, 0, 0, 1);
    chk("lap_release", display, 8'h07);

    // Start with clear during RUN; start with stop during PAUSE.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    idle(8);
    chk("pre_clear_04", display, 8'h04);
    step(1, 0, 1, 0);
    chk("startclear_display", display, 8'h00);
    chk("startclear_running", running, 0);
    step(1, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("startstop_pause", running, 0);
    idle(4);
    chk("startstop_still_paused", running, 0);

    // Asynchronous reset mid-cycle during RUN.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    idle(24);
    chk("pre_reset_12", display, 8'h12);
    #20;
    reset = 1'b1;
    start = 1'b1;
    #5;
    chk("async_reset_display", display, 8'h00);
    chk("async_reset_running", running, 0);
    model_reset();
    @(posedge clock);
    #2;
    chk("reset_ignores_start", running, 0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    idle(3);
    chk("after_reset_idle", display, 8'h00);
    step(1, 0, 0, 0);
    idle(2);
    chk("after_reset_count", display, 8'h01);

    // Random command mix.
    for (int i = 0; i < 600; i++) begin
      bit st, sp, cl, lp;
      cl = ($urandom_range(0, 59) == 0);
      sp = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 7) == 0);
      lp = ($urandom_range(0, 13) == 0);
      step(st, sp, cl, lp);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
